mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 4-input, 4-bit-wide multiplexer datapath. Four requesters compete for one output channel. The block grants one requester at a time and drives the registered mux select. It holds the grant for a multi-beat burst under a valid/ready handshake, then rotates priority.

---
 rtl/mux4_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter and sequencer for a shared 4-input mux.
// It grants one requester at a time, holds the grant for a valid/ready burst,
// and then rotates priority so the last winner becomes lowest priority.
// Optional feature macro: MUX4_ARB_BURST_LIMIT_EN caps each grant at BURST_MAX
// transferred beats.
module mux4_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int BURST_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       last,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       grant,
  output logic [1:0]       sel
);

  // Reject an illegal burst length when the design is elaborated.
  generate
    if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_bad_burst_max
      $error("mux4_rr_arbiter: BURST_MAX must be in 1..255");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic       pick_vld;
  logic [1:0] pick_idx;
  logic [1:0] scan_idx;
  logic       busy;
  logic       xfer;
  logic       release_c;

`ifdef MUX4_ARB_BURST_LIMIT_EN
  logic [7:0] cnt;
  logic       limit_hit;
`endif

  // Round-robin pick: scan ptr+1, ptr+2, ptr+3, ptr; the nearest set bit wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr;
    scan_idx = ptr;
    for (int k = 4; k >= 1; k--) begin
      scan_idx = ptr + 2'(k);
      if (req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  assign busy      = (state == BUSY);
  assign out_valid = busy & req[sel];
  assign xfer      = out_valid & out_ready;

`ifdef MUX4_ARB_BURST_LIMIT_EN
  assign limit_hit = xfer & (cnt == 8'(BURST_MAX - 1));
  assign release_c = ~req[sel] | (xfer & last[sel]) | limit_hit;
`else
  assign release_c = ~req[sel] | (xfer & last[sel]);
`endif

  // AND/OR mux gated by the one-hot grant; an idle arbiter drives zero.
  always_comb begin
    out_data = ({WIDTH{grant[0]}} & d0) |
               ({WIDTH{grant[1]}} & d1) |
               ({WIDTH{grant[2]}} & d2) |
               ({WIDTH{grant[3]}} & d3);
  end

  // Arbitration FSM with registered grant, select, pointer and beat count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      grant <= 4'b0000;
      sel   <= 2'd0;
      ptr   <= 2'd3;
`ifdef MUX4_ARB_BURST_LIMIT_EN
      cnt   <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= 4'b0001 << pick_idx;
            sel   <= pick_idx;
            state <= BUSY;
`ifdef MUX4_ARB_BURST_LIMIT_EN
            cnt   <= 8'd0;
`endif
          end
        end
        BUSY: begin
          if (release_c) begin
            ptr   <= sel;
            grant <= 4'b0000;
            state <= IDLE;
          end
`ifdef MUX4_ARB_BURST_LIMIT_EN
          if (xfer) cnt <= cnt + 8'd1;
`endif
        end
        default: begin
          state <= IDLE;
          grant <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed, table-driven bench for mux4_rr_arbiter with a few hand-written
// multi-cycle sequences (burst limit or unlimited streaming).
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, last;
  logic [3:0] d0, d1, d2, d3;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [3:0] grant;
  logic [1:0] sel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.WIDTH(4), .BURST_MAX(8)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .grant(grant), .sel(sel)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    logic [3:0] eg;
    logic [1:0] es;
    logic       ev;
    logic [3:0] ed;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                     input logic rd, input logic [3:0] eg, input logic [1:0] es,
                     input logic ev, input logic [3:0] ed);
    vec_t v;
    v.rst = r; v.req = rq; v.last = ls; v.rdy = rd;
    v.eg = eg; v.es = es; v.ev = ev; v.ed = ed;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [3:0] eg, input logic [1:0] es,
                           input logic ev, input logic [3:0] ed);
    chk("grant", idx, 32'(grant), 32'(eg));
    chk("sel", idx, 32'(sel), 32'(es));
    chk("out_valid", idx, 32'(out_valid), 32'(ev));
    chk("out_data", idx, 32'(out_data), 32'(ed));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    d0 = 4'h3; d1 = 4'h5; d2 = 4'hA; d3 = 4'hC;
    rst = 1'b0; req = 4'b0; last = 4'b0; out_ready = 1'b0;

    // Each row: inputs for this cycle, outputs expected before the next edge.
    // Reset state.
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 4'h0);
    // Full rotation 0,1,2,3,0 with single-cycle bubbles.
    add(1, 4'b1111, 4'b1111, 1, 4'b0000, 2'd0, 0, 4'h0);
    add(1, 4'b1111, 4'b1111, 1, 4'b0001, 2'd0, 1, 4'h3);
    add(1, 4'b1111, 4'b1111, 1, 4'b0000, 2'd0, 0, 4'h0);
    add(1, 4'b1111, 4'b1111, 1, 4'b0010, 2'd1, 1, 4'h5);
    add(1, 4'b1111, 4'b1111, 1, 4'b0000, 2'd1, 0, 4'h0);
    add(1, 4'b1111, 4'b1111, 1, 4'b0100, 2'd2, 1, 4'hA);
    add(1, 4'b1111, 4'b1111, 1, 4'b0000, 2'd2, 0, 4'h0);
    add(1, 4'b1111, 4'b1111, 1, 4'b1000, 2'd3, 1, 4'hC);
    add(1, 4'b1111, 4'b1111, 1, 4'b0000, 2'd3, 0, 4'h0);
    add(1, 4'b1111, 4'b1111, 1, 4'b0001, 2'd0, 1, 4'h3);
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0, 0, 4'h0);
    // Requester 2: three beats of 4'hA, last on the third, then a bubble.
    add(1, 4'b0100, 4'b0000, 1, 4'b0000, 2'd0, 0, 4'h0);
    add(1, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 1, 4'hA);
    add(1, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 1, 4'hA);
    add(1, 4'b0100, 4'b0100, 1, 4'b0100, 2'd2, 1, 4'hA);
    add(1, 4'b0100, 4'b0000, 1, 4'b0000, 2'd2, 0, 4'h0);
    // Regranted 2, then abort: data still muxed, valid low.
    add(1, 4'b0000, 4'b0000, 1, 4'b0100, 2'd2, 0, 4'hA);
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 2'd2, 0, 4'h0);
    // Requester 1 stalled five cycles, then completes.
    add(1, 4'b0010, 4'b0010, 0, 4'b0000, 2'd2, 0, 4'h0);
    for (int i = 0; i < 5; i++)
      add(1, 4'b0010, 4'b0010, 0, 4'b0010, 2'd1, 1, 4'h5);
    add(1, 4'b0010, 4'b0010, 1, 4'b0010, 2'd1, 1, 4'h5);
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 2'd1, 0, 4'h0);
    // Requester 2 aborts mid-burst; ptr=2 sends the next grant to 3.
    add(1, 4'b0100, 4'b0000, 1, 4'b0000, 2'd1, 0, 4'h0);
    add(1, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 1, 4'hA);
    add(1, 4'b1000, 4'b0000, 1, 4'b0100, 2'd2, 0, 4'hA);
    add(1, 4'b1001, 4'b0000, 1, 4'b0000, 2'd2, 0, 4'h0);
    add(1, 4'b1001, 4'b1000, 1, 4'b1000, 2'd3, 1, 4'hC);
    // Move ptr to 0, grant 2, then reset mid-burst.
    add(1, 4'b0001, 4'b0001, 1, 4'b0000, 2'd3, 0, 4'h0);
    add(1, 4'b0001, 4'b0001, 1, 4'b0001, 2'd0, 1, 4'h3);
    add(1, 4'b0100, 4'b0000, 1, 4'b0000, 2'd0, 0, 4'h0);
    add(1, 4'b1111, 4'b0000, 1, 4'b0100, 2'd2, 1, 4'hA);
    add(0, 4'b1111, 4'b0000, 1, 4'b0100, 2'd2, 1, 4'hA);
    // After reset the first grant goes to requester 0.
    add(1, 4'b1111, 4'b0000, 1, 4'b0000, 2'd0, 0, 4'h0);
    add(1, 4'b1111, 4'b0000, 1, 4'b0001, 2'd0, 1, 4'h3);
    add(1, 4'b0000, 4'b0000, 1, 4'b0001, 2'd0, 0, 4'h3);
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0, 0, 4'h0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].rst; req = tv[i].req; last = tv[i].last; out_ready = tv[i].rdy;
      #1;
      check_all(i, tv[i].eg, tv[i].es, tv[i].ev, tv[i].ed);
      tick();
    end

    // Requester 3 streams with last=0 (ptr is 0 here).
    rst = 1'b1; req = 4'b1000; last = 4'b0000; out_ready = 1'b1;
    #1;
    check_all(100, 4'b0000, 2'd0, 0, 4'h0);
    tick();
`ifdef MUX4_ARB_BURST_LIMIT_EN
    for (int b = 0; b < 8; b++) begin
      req = (b == 7) ? 4'b1001 : 4'b1000;
      #1;
      check_all(101 + b, 4'b1000, 2'd3, 1, 4'hC);
      tick();
    end
    req = 4'b1001;
    #1;
    check_all(110, 4'b0000, 2'd3, 0, 4'h0);
    tick();
    #1;
    check_all(111, 4'b0001, 2'd0, 1, 4'h3);
`else
    for (int b = 0; b < 12; b++) begin
      #1;
      check_all(101 + b, 4'b1000, 2'd3, 1, 4'hC);
      tick();
    end
    req = 4'b0000;
    #1;
    check_all(120, 4'b1000, 2'd3, 0, 4'hC);
    tick();
    #1;
    check_all(121, 4'b0000, 2'd3, 0, 4'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
